line_window_buffer: RTL and testbench
=====================================

LINE_WINDOW_BUFFER -- requirements
Module: line_window_buffer

Interface
REQ-001 SHALL be clocked by a single clock; reset is synchronous and active-high.
REQ-002 Parameter IMG_WIDTH, default 512: pixels per image line (any value >= TAPS, not required to be a power of two).
REQ-003 Parameter PIX_W, default 8: bits per pixel.
REQ-004 Parameter TAPS, default 3: horizontal window size (odd, 3..7).
REQ-005 Parameter EDGE_MODE, default 0: right-edge handling (0 = replicate last column, 1 = zero fill).
REQ-006 clk  in  1  clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 in_pixel  in  PIX_W  incoming pixel, raster order.
REQ-009 in_valid  in  1  in_pixel is valid this cycle.
REQ-010 in_ready  out  1  buffer can accept a pixel this cycle.
REQ-011 rd_en  in  1  consumer advances the window by one column.
REQ-012 out_window  out  TAPS*PIX_W  window; tap 0 (current column) in the MSBs, tap TAPS-1 in the LSBs.
REQ-013 out_valid  out  1  out_window holds a complete window.
REQ-014 line_done  out  1  one-cycle pulse when the last column of a line is consumed.
REQ-015 level  out  $clog2(IMG_WIDTH+1)  pixels stored and not yet consumed.
REQ-016 rd_err  out  1  sticky flag: rd_en asserted while out_valid = 0.

Function
REQ-017 Storage SHALL be IMG_WIDTH x PIX_W entries, with write pointer wr_ptr and read pointer rd_ptr.
REQ-018 Both pointers SHALL wrap from IMG_WIDTH-1 to 0, so rd_ptr always equals the current column index.
REQ-019 Write accept = in_valid && in_ready; on accept, store in_pixel at wr_ptr and increment wr_ptr.
REQ-020 in_ready SHALL be combinational: (level < IMG_WIDTH).
REQ-021 in_valid while in_ready = 0 SHALL be dropped with no state change.
REQ-022 need = min(TAPS, IMG_WIDTH - rd_ptr).
REQ-023 out_valid SHALL be combinational: (level >= need).
REQ-024 Read accept = rd_en && out_valid; on accept, increment rd_ptr.
REQ-025 level SHALL update as follows: +1 on write accept only, -1 on read accept only, unchanged when both or neither occur.
REQ-026 out_window SHALL be combinational from storage and rd_ptr (prefetch, no read latency).
REQ-027 Tap k SHALL be the pixel at column rd_ptr+k when rd_ptr+k <= IMG_WIDTH-1.
REQ-028 Tap k with rd_ptr+k > IMG_WIDTH-1 SHALL be the pixel at column IMG_WIDTH-1 when EDGE_MODE = 0, and all-zero when EDGE_MODE = 1.
REQ-029 Taps SHALL never wrap into column 0 of the next line.
REQ-030 out_window is don't-care while out_valid = 0.
REQ-031 A write SHALL never overwrite an entry inside the current window; this is guaranteed by the level accounting.
REQ-032 line_done SHALL be a registered pulse, high for exactly one cycle, in the cycle after a read accept with rd_ptr = IMG_WIDTH-1.
REQ-033 rd_err SHALL set on rd_en && !out_valid, SHALL clear only on reset, and such an rd_en SHALL not move rd_ptr.
REQ-034 Continuous streaming (write and read accepted every cycle) SHALL sustain one pixel per cycle in each direction across line boundaries.

Reset
REQ-035 On rst = 1 at a clock edge: wr_ptr = 0, rd_ptr = 0, level = 0, line_done = 0, rd_err = 0.
REQ-036 Storage contents are not reset.
REQ-037 After reset, outputs SHALL read in_ready = 1 and out_valid = 0.
REQ-038 Reset asserted mid-line SHALL discard all stored pixels; the next accepted pixel is column 0.

Verification
REQ-039 All scenarios below use IMG_WIDTH = 8, TAPS = 3, PIX_W = 8.
REQ-040 Reset and fill:
- Apply reset -> in_ready = 1, out_valid = 0, level = 0, rd_err = 0.
- Write 0x10..0x17 with no reads -> level = 8, in_ready = 0, out_valid = 1, out_window = {10,11,12}.
REQ-041 Replicate drain (EDGE_MODE = 0), read 8 times back-to-back:
- Windows {10,11,12}, {11,12,13} ... {15,16,17}, then {16,17,17}, then {17,17,17}.
- line_done high for one cycle after the 8th read; level = 0; out_valid = 0.
REQ-042 Zero fill (EDGE_MODE = 1), same data:
- Column 6 window = {16,17,00}; column 7 window = {17,00,00}.
REQ-043 Partial and error cases:
- After 2 writes -> out_valid = 0.
- After the 3rd write -> out_valid = 1.
- rd_en while out_valid = 0 -> rd_err = 1 and rd_ptr unchanged.
- A 9th write while full -> dropped; level stays 8 and the data is unchanged.
REQ-044 Streaming: simultaneous write and read every cycle across 3 lines -> level constant, line_done pulses every 8 reads, windows match a reference model.
REQ-045 Mid-operation reset: 5 writes, 2 reads, then rst for 1 cycle -> level = 0, out_valid = 0, rd_err = 0; a new line written afterwards reads back from column 0 correctly.

Source files
------------

// File: rtl/line_window_buffer.sv
// Single-line pixel buffer that presents a TAPS-wide horizontal window per column,
// with right-edge replicate or zero fill and level-based flow control.
module line_window_buffer #(
  parameter int unsigned IMG_WIDTH = 512,
  parameter int unsigned PIX_W     = 8,
  parameter int unsigned TAPS      = 3,
  parameter int unsigned EDGE_MODE = 0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [PIX_W-1:0]                 in_pixel,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             rd_en,
  output logic [TAPS*PIX_W-1:0]            out_window,
  output logic                             out_valid,
  output logic                             line_done,
  output logic [$clog2(IMG_WIDTH+1)-1:0]   level,
  output logic                             rd_err
);

  localparam int unsigned LW = $clog2(IMG_WIDTH + 1);
  localparam int unsigned PW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam logic [PW-1:0] LAST_COL = PW'(IMG_WIDTH - 1);
  localparam logic [LW-1:0] FULL_LVL = LW'(IMG_WIDTH);

  logic [PIX_W-1:0] mem_q [IMG_WIDTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          line_done_q, line_done_d;
  logic          rd_err_q, rd_err_d;

  logic [31:0]   remain_c;
  logic [31:0]   need_c;
  logic          wr_acc_c;
  logic          rd_acc_c;

  // Columns left in the line bound how many pixels a window really needs.
  assign remain_c  = 32'(IMG_WIDTH) - 32'(rd_ptr_q);
  assign need_c    = (remain_c < 32'(TAPS)) ? remain_c : 32'(TAPS);

  assign in_ready  = (level_q < FULL_LVL);
  assign out_valid = (32'(level_q) >= need_c);
  assign wr_acc_c  = in_valid && in_ready;
  assign rd_acc_c  = rd_en && out_valid;

  assign level     = level_q;
  assign line_done = line_done_q;
  assign rd_err    = rd_err_q;

  // Window taps past the last column never wrap into the next line.
  always_comb begin : win_mux
    logic [31:0]      col;
    logic [PIX_W-1:0] tap;
    out_window = '0;
    col        = '0;
    tap        = '0;
    for (int k = 0; k < int'(TAPS); k++) begin
      col = 32'(rd_ptr_q) + 32'(k);
      if (col <= 32'(IMG_WIDTH - 1)) begin
        tap = mem_q[PW'(col)];
      end else if (EDGE_MODE == 0) begin
        tap = mem_q[LAST_COL];
      end else begin
        tap = '0;
      end
      out_window[(int'(TAPS) - 1 - k)*int'(PIX_W) +: int'(PIX_W)] = tap;
    end
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    line_done_d = 1'b0;
    rd_err_d    = rd_err_q;

    if (wr_acc_c) begin
      wr_ptr_d = (wr_ptr_q == LAST_COL) ? '0 : wr_ptr_q + PW'(1);
    end
    if (rd_acc_c) begin
      rd_ptr_d    = (rd_ptr_q == LAST_COL) ? '0 : rd_ptr_q + PW'(1);
      line_done_d = (rd_ptr_q == LAST_COL);
    end
    case ({wr_acc_c, rd_acc_c})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (rd_en && !out_valid) begin
      rd_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      line_done_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      line_done_q <= line_done_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Pixel storage is not reset; level accounting masks stale entries.
  always_ff @(posedge clk) begin
    if (wr_acc_c) begin
      mem_q[wr_ptr_q] <= in_pixel;
    end
  end

endmodule

// File: tb/tb_line_window_buffer.sv
// Bench for line_window_buffer: queue-based line model checked every cycle on
// replicate and zero-fill instances, plus hand-computed directed checks.
module tb_line_window_buffer;

  localparam int W = 8;
  localparam int T = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_pixel = '0;
  logic        in_valid = 1'b0;
  logic        rd_en = 1'b0;

  logic        in_ready0, in_ready1;
  logic [23:0] win0, win1;
  logic        out_valid0, out_valid1;
  logic        line_done0, line_done1;
  logic [3:0]  level0, level1;
  logic        rd_err0, rd_err1;

  int total = 0;
  int bad = 0;

  line_window_buffer #(.IMG_WIDTH(W), .PIX_W(8), .TAPS(T), .EDGE_MODE(0)) dut_rep (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready0), .rd_en(rd_en), .out_window(win0),
    .out_valid(out_valid0), .line_done(line_done0), .level(level0), .rd_err(rd_err0)
  );

  line_window_buffer #(.IMG_WIDTH(W), .PIX_W(8), .TAPS(T), .EDGE_MODE(1)) dut_zero (
    .clk(clk), .rst(rst), .in_pixel(in_pixel), .in_valid(in_valid),
    .in_ready(in_ready1), .rd_en(rd_en), .out_window(win1),
    .out_valid(out_valid1), .line_done(line_done1), .level(level1), .rd_err(rd_err1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: unconsumed pixels in raster order plus current column.
  int q[$];
  int col_m = 0;
  bit ld_m = 0;
  bit err_m = 0;
  bit ok_m = 0;

  function automatic int need_m();
    return (W - col_m < T) ? (W - col_m) : T;
  endfunction

  function automatic logic [23:0] win_m(input bit zero_fill);
    logic [23:0] r;
    int v;
    r = '0;
    for (int k = 0; k < T; k++) begin
      if (col_m + k <= W - 1) v = q[k];
      else v = zero_fill ? 0 : q[W - 1 - col_m];
      r = {r[15:0], 8'(v)};
    end
    return r;
  endfunction

  always @(negedge clk) begin
    bit mv, rdy, ra, wa;
    if (ok_m) begin
      mv  = (q.size() >= need_m());
      rdy = (q.size() < W);
      chk("m_in_ready0", 64'(in_ready0), 64'(rdy));
      chk("m_in_ready1", 64'(in_ready1), 64'(rdy));
      chk("m_out_valid0", 64'(out_valid0), 64'(mv));
      chk("m_out_valid1", 64'(out_valid1), 64'(mv));
      chk("m_level0", 64'(level0), 64'(q.size()));
      chk("m_level1", 64'(level1), 64'(q.size()));
      chk("m_line_done0", 64'(line_done0), 64'(ld_m));
      chk("m_line_done1", 64'(line_done1), 64'(ld_m));
      chk("m_rd_err0", 64'(rd_err0), 64'(err_m));
      chk("m_rd_err1", 64'(rd_err1), 64'(err_m));
      if (mv) begin
        chk("m_win_rep", 64'(win0), 64'(win_m(1'b0)));
        chk("m_win_zero", 64'(win1), 64'(win_m(1'b1)));
      end
    end
    if (rst) begin
      q.delete();
      col_m = 0;
      ld_m  = 0;
      err_m = 0;
      ok_m  = 1;
    end else if (ok_m) begin
      mv  = (q.size() >= need_m());
      rdy = (q.size() < W);
      ra  = rd_en && mv;
      wa  = in_valid && rdy;
      if (rd_en && !mv) err_m = 1;
      ld_m = ra && (col_m == W - 1);
      if (ra) begin
        void'(q.pop_front());
        col_m = (col_m + 1) % W;
      end
      if (wa) q.push_back(int'(in_pixel));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic write_px(input logic [7:0] p);
    in_pixel = p;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  logic [23:0] exp_rep  [8] = '{24'h101112, 24'h111213, 24'h121314, 24'h131415,
                                24'h141516, 24'h151617, 24'h161717, 24'h171717};
  logic [23:0] exp_zero [8] = '{24'h101112, 24'h111213, 24'h121314, 24'h131415,
                                24'h141516, 24'h151617, 24'h161700, 24'h170000};

  initial begin
    int pulses;
    // Reset and fill
    do_reset(2);
    chk("rst_in_ready", 64'(in_ready0), 64'd1);
    chk("rst_out_valid", 64'(out_valid0), 64'd0);
    chk("rst_level", 64'(level0), 64'd0);
    chk("rst_rd_err", 64'(rd_err0), 64'd0);
    for (int i = 0; i < 8; i++) write_px(8'(8'h10 + i));
    chk("fill_level", 64'(level0), 64'd8);
    chk("fill_in_ready", 64'(in_ready0), 64'd0);
    chk("fill_out_valid", 64'(out_valid0), 64'd1);
    chk("fill_win_rep", 64'(win0), 64'h101112);
    chk("fill_win_zero", 64'(win1), 64'h101112);
    write_px(8'hAA);
    chk("drop_level", 64'(level0), 64'd8);
    chk("drop_win", 64'(win0), 64'h101112);

    // Drain both edge modes
    rd_en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk($sformatf("drain_rep_c%0d", c), 64'(win0), 64'(exp_rep[c]));
      chk($sformatf("drain_zero_c%0d", c), 64'(win1), 64'(exp_zero[c]));
      chk("drain_line_done_low", 64'(line_done0), 64'd0);
      tick();
    end
    rd_en = 1'b0;
    chk("drain_line_done", 64'(line_done0), 64'd1);
    chk("drain_level", 64'(level0), 64'd0);
    chk("drain_out_valid", 64'(out_valid0), 64'd0);
    tick();
    chk("drain_line_done_pulse", 64'(line_done0), 64'd0);

    // Partial and error cases
    do_reset(1);
    write_px(8'h10);
    write_px(8'h11);
    chk("part2_out_valid", 64'(out_valid0), 64'd0);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk("err_rd_err", 64'(rd_err0), 64'd1);
    chk("err_level", 64'(level0), 64'd2);
    write_px(8'h12);
    chk("part3_out_valid", 64'(out_valid0), 64'd1);
    chk("part3_win", 64'(win0), 64'h101112);
    chk("err_sticky", 64'(rd_err0), 64'd1);

    // Streaming across three lines
    do_reset(1);
    for (int i = 0; i < 3; i++) write_px(8'($urandom_range(0, 255)));
    pulses = 0;
    in_valid = 1'b1;
    rd_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      in_pixel = 8'($urandom_range(0, 255));
      tick();
      chk("stream_level", 64'(level0), 64'd3);
      if (line_done0 === 1'b1) pulses++;
    end
    in_valid = 1'b0;
    rd_en = 1'b0;
    chk("stream_pulses", 64'(pulses), 64'd3);

    // Mid-operation reset
    do_reset(1);
    for (int i = 0; i < 5; i++) write_px(8'(8'h30 + i));
    rd_en = 1'b1;
    tick();
    tick();
    rd_en = 1'b0;
    chk("mid_level_pre", 64'(level0), 64'd3);
    do_reset(1);
    chk("mid_level", 64'(level0), 64'd0);
    chk("mid_out_valid", 64'(out_valid0), 64'd0);
    chk("mid_rd_err", 64'(rd_err0), 64'd0);
    chk("mid_in_ready", 64'(in_ready0), 64'd1);
    for (int i = 0; i < 8; i++) write_px(8'(8'h20 + i));
    chk("mid_win_c0", 64'(win0), 64'h202122);
    rd_en = 1'b1;
    tick();
    chk("mid_win_c1", 64'(win0), 64'h212223);
    repeat (7) tick();
    rd_en = 1'b0;
    chk("mid_line_done", 64'(line_done0), 64'd1);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
